// File: rtl/norm_check_defines_pkg.sv
// Shared types and default bounds for the multi-lane ML-DSA infinity-norm checker.
package norm_check_defines_pkg;

   typedef enum logic [1:0] {
      CHK_Z_BOUND    = 2'd0,
      CHK_R0_BOUND   = 2'd1,
      CHK_CT0_BOUND  = 2'd2,
      CHK_USER_BOUND = 2'd3
   } chk_norm_mode_t;

   typedef enum logic [1:0] {
      CHK_IDLE   = 2'd0,
      CHK_RD_MEM = 2'd1,
      CHK_WAIT   = 2'd2,
      CHK_DONE   = 2'd3
   } chk_read_state_e;

   localparam int unsigned DILITHIUM_Q_DEF = 8380417;
   localparam int unsigned Z_BOUND_DEF     = 524092;   // gamma1 - beta
   localparam int unsigned R0_BOUND_DEF    = 261692;   // gamma2 - beta
   localparam int unsigned CT0_BOUND_DEF   = 261888;   // gamma2

endpackage

// File: rtl/norm_check_lane.sv
// One coefficient lane: centre a value mod Q and flag it when |c| reaches the bound.
module norm_check_lane
   import norm_check_defines_pkg::*;
#(
   parameter int unsigned COEFF_W = 24,
   parameter int unsigned Q       = DILITHIUM_Q_DEF
) (
   input  logic [COEFF_W-1:0] coeff,
   input  logic [COEFF_W-1:0] bound,
   output logic               fail
);

   localparam logic [COEFF_W-1:0] Q_C    = COEFF_W'(Q);
   localparam logic [COEFF_W-1:0] HALF_Q = COEFF_W'((Q - 1) / 2);

   logic [COEFF_W-1:0] abs_val;

   // Values at or above Q are malformed and always fail
   always_comb begin
      abs_val = coeff;
      if (coeff > HALF_Q) begin
         abs_val = Q_C - coeff;
      end
      fail = (coeff >= Q_C) || (abs_val >= bound);
   end

endmodule

// File: rtl/norm_check_multilane.sv
// Streams NUM_POLY polynomials from memory and checks every centred coefficient against a bound.
module norm_check_multilane
   import norm_check_defines_pkg::*;
#(
   parameter int unsigned NUM_LANES    = 4,
   parameter int unsigned COEFF_W      = 24,
   parameter int unsigned MEM_ADDR_W   = 15,
   parameter int unsigned NUM_POLY_MAX = 8,
   parameter int unsigned DILITHIUM_Q  = DILITHIUM_Q_DEF,
   parameter int unsigned Z_BOUND      = Z_BOUND_DEF,
   parameter int unsigned R0_BOUND     = R0_BOUND_DEF,
   parameter int unsigned CT0_BOUND    = CT0_BOUND_DEF
) (
   input  logic                                            clk,
   input  logic                                            reset,
   input  logic                                            zeroize,
   input  logic                                            en,
   input  logic [1:0]                                      mode,
   input  logic [COEFF_W-1:0]                              user_bound,
   input  logic [$clog2(NUM_POLY_MAX):0]                   num_poly,
   input  logic                                            abort_on_fail,
   input  logic [MEM_ADDR_W-1:0]                           mem_base_addr,
   output logic                                            mem_rd_en,
   output logic [MEM_ADDR_W-1:0]                           mem_rd_addr,
   input  logic [NUM_LANES*COEFF_W-1:0]                    mem_rd_data,
   output logic                                            busy,
   output logic                                            done,
   output logic                                            invalid,
   output logic [$clog2(NUM_POLY_MAX*256/NUM_LANES)-1:0]   fail_word,
   output logic [NUM_LANES-1:0]                            fail_lane_mask
);

   localparam int unsigned WORDS_PER_POLY = 256 / NUM_LANES;
   localparam int unsigned NP_W           = $clog2(NUM_POLY_MAX) + 1;
   localparam int unsigned FW_W           = $clog2(NUM_POLY_MAX * WORDS_PER_POLY);
   localparam int unsigned CNT_W          = FW_W + 1;

   chk_read_state_e        state_q, state_d;

   logic [COEFF_W-1:0]     bound_q, bound_c;
   logic [CNT_W-1:0]       n_words_q, n_words_c;
   logic [NP_W-1:0]        np_clamp;
   logic                   abort_q;
   logic [MEM_ADDR_W-1:0]  addr_q;
   logic [CNT_W-1:0]       word_cnt_q;
   logic                   wait_cnt_q;
   logic                   rd_vld_q;
   logic [FW_W-1:0]        rd_word_q;
   logic [NUM_LANES-1:0]   lane_fail;
   logic                   accept;
   logic                   last_rd;

   // Run configuration captured at the accepting edge
   always_comb begin
      np_clamp = (num_poly > NP_W'(NUM_POLY_MAX)) ? NP_W'(NUM_POLY_MAX) : num_poly;
      n_words_c = CNT_W'(np_clamp) * CNT_W'(WORDS_PER_POLY);
      bound_c = user_bound;
      case (chk_norm_mode_t'(mode))
         CHK_Z_BOUND:   bound_c = COEFF_W'(Z_BOUND);
         CHK_R0_BOUND:  bound_c = COEFF_W'(R0_BOUND);
         CHK_CT0_BOUND: bound_c = COEFF_W'(CT0_BOUND);
         default:       bound_c = user_bound;
      endcase
   end

   assign accept  = (state_q == CHK_IDLE) && en;
   assign last_rd = (word_cnt_q == n_words_q - CNT_W'(1));

   always_ff @(posedge clk or posedge reset) begin : p_state_reg
      if (reset) begin
         state_q <= CHK_IDLE;
      end else if (zeroize) begin
         state_q <= CHK_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin : p_next_state
      state_d = state_q;
      case (state_q)
         CHK_IDLE: begin
            if (en) begin
               state_d = (np_clamp == '0) ? CHK_DONE : CHK_RD_MEM;
            end
         end
         CHK_RD_MEM: begin
            if (last_rd || (abort_q && invalid)) begin
               state_d = CHK_WAIT;
            end
         end
         CHK_WAIT: begin
            if (wait_cnt_q) begin
               state_d = CHK_DONE;
            end
         end
         default: state_d = CHK_IDLE;
      endcase
   end

   always_comb begin : p_outputs
      mem_rd_en = 1'b0;
      busy      = 1'b0;
      done      = 1'b0;
      case (state_q)
         CHK_RD_MEM: begin
            mem_rd_en = 1'b1;
            busy      = 1'b1;
         end
         CHK_WAIT: busy = 1'b1;
         CHK_DONE: begin
            busy = 1'b1;
            done = 1'b1;
         end
         default: ;
      endcase
   end

   assign mem_rd_addr = addr_q;

   for (genvar i = 0; i < NUM_LANES; i++) begin : g_lane
      norm_check_lane #(
         .COEFF_W (COEFF_W),
         .Q       (DILITHIUM_Q)
      ) u_lane (
         .coeff (mem_rd_data[i*COEFF_W +: COEFF_W]),
         .bound (bound_q),
         .fail  (lane_fail[i])
      );
   end

   // Read counters, data-valid tracking and first-failure capture
   always_ff @(posedge clk or posedge reset) begin : p_datapath
      if (reset) begin
         bound_q        <= '0;
         n_words_q      <= '0;
         abort_q        <= 1'b0;
         addr_q         <= '0;
         word_cnt_q     <= '0;
         wait_cnt_q     <= 1'b0;
         rd_vld_q       <= 1'b0;
         rd_word_q      <= '0;
         invalid        <= 1'b0;
         fail_word      <= '0;
         fail_lane_mask <= '0;
      end else if (zeroize) begin
         bound_q        <= '0;
         n_words_q      <= '0;
         abort_q        <= 1'b0;
         addr_q         <= '0;
         word_cnt_q     <= '0;
         wait_cnt_q     <= 1'b0;
         rd_vld_q       <= 1'b0;
         rd_word_q      <= '0;
         invalid        <= 1'b0;
         fail_word      <= '0;
         fail_lane_mask <= '0;
      end else begin
         rd_vld_q  <= mem_rd_en;
         rd_word_q <= FW_W'(word_cnt_q);
         if (accept) begin
            bound_q        <= bound_c;
            n_words_q      <= n_words_c;
            abort_q        <= abort_on_fail;
            addr_q         <= mem_base_addr;
            word_cnt_q     <= '0;
            wait_cnt_q     <= 1'b0;
            invalid        <= 1'b0;
            fail_word      <= '0;
            fail_lane_mask <= '0;
         end
         if (mem_rd_en) begin
            word_cnt_q <= word_cnt_q + CNT_W'(1);
            addr_q     <= addr_q + MEM_ADDR_W'(1);
         end
         if (state_q == CHK_WAIT) begin
            wait_cnt_q <= ~wait_cnt_q;
         end
         // Only the first failing word is recorded; invalid doubles as the captured flag
         if (rd_vld_q && (|lane_fail) && !invalid) begin
            invalid        <= 1'b1;
            fail_word      <= rd_word_q;
            fail_lane_mask <= lane_fail;
         end
      end
   end

endmodule

// File: doc/norm_check_multilane.md
Name: norm_check_multilane

Overview:
- Parametrised infinity-norm validity checker for ML-DSA signing and verify.
- Streams NUM_POLY polynomials from coefficient memory, NUM_LANES centred coefficients per word, and compares each |c| against a mode-selected bound.
- Adds over the single-lane checker: lane parallelism, variable polynomial count, a runtime user bound mode, early abort, and first-failure reporting.
- Sits between the sampler/NTT memories and the signing control FSM.

Parameters:
- NUM_LANES, 4, coefficients per memory word (power of two, 1..8)
- COEFF_W, 24, coefficient width
- MEM_ADDR_W, 15, memory address width
- NUM_POLY_MAX, 8, maximum polynomials per run
- DILITHIUM_Q, 8380417, modulus
- Z_BOUND, 524092, gamma1-beta
- R0_BOUND, 261692, gamma2-beta
- CT0_BOUND, 261888, gamma2

Ports:
- clk  in  1  clock
- reset  in  1  asynchronous active-high reset
- zeroize  in  1  synchronous clear
- en  in  1  start pulse, sampled only in CHK_IDLE
- mode  in  2  chk_norm_mode_t: z_bound, r0_bound, ct0_bound, user_bound
- user_bound  in  COEFF_W  bound used when mode=user_bound
- num_poly  in  $clog2(NUM_POLY_MAX)+1  polynomial count
- abort_on_fail  in  1  stop reading at first failure
- mem_base_addr  in  MEM_ADDR_W  first word address
- mem_rd_en  out  1  memory read request
- mem_rd_addr  out  MEM_ADDR_W  read address
- mem_rd_data  in  NUM_LANES*COEFF_W  read data, lane 0 in LSBs, 1-cycle latency
- busy  out  1  high in every state except CHK_IDLE
- done  out  1  one-cycle pulse in CHK_DONE
- invalid  out  1  sticky result, valid from done until next accepted en
- fail_word  out  $clog2(NUM_POLY_MAX*256/NUM_LANES)  word index of first failure
- fail_lane_mask  out  NUM_LANES  failing lanes in that word

Behaviour:
- Reset and zeroize: all outputs 0, state CHK_IDLE, counters 0. Zeroize has priority over en, mid-run included. No done pulse is issued.
- Mode and bound latching: mode, bound, num_poly, abort_on_fail and mem_base_addr are latched when en is accepted. Input changes during a run are ignored.
- Run setup: N = num_poly*256/NUM_LANES words. Accepting en clears invalid, fail_word and fail_lane_mask.
- FSM:
  - CHK_IDLE -en-> CHK_RD_MEM.
  - CHK_RD_MEM issues one read per cycle: mem_rd_en=1, addr = base + word counter, modulo 2^MEM_ADDR_W.
  - After the Nth read, or on abort, go to CHK_WAIT.
  - CHK_WAIT lasts exactly 2 cycles (pipeline drain), then CHK_DONE.
  - CHK_DONE asserts done for 1 cycle, then returns to CHK_IDLE.
- Pipeline:
  - Read issued at cycle t; data arrives at t+1.
  - Per-lane compare happens combinationally at t+1 and is registered at t+2 into the fail flags.
  - invalid is the sticky OR of all registered fail flags.
- Latency: en accepted at edge k gives rd_en in cycles k+1..k+N and done in cycle k+N+3. Example: num_poly=1, NUM_LANES=4 gives done at k+67.
- Lane arithmetic:
  - Coefficient c >= Q: fail, as malformed input.
  - c <= (Q-1)/2: abs = c.
  - Otherwise: abs = Q-c.
  - Fail when abs >= bound. The comparison is unsigned, COEFF_W bits.
- First failure: fail_word and fail_lane_mask capture only the first failing word. Later failures set nothing new.
- Early abort: with abort_on_fail=1, the registered fail (t+2) stops reads the next cycle. Up to 2 extra reads may already be issued; their results are ignored for fail_word. The FSM then goes to CHK_WAIT, then CHK_DONE.
- num_poly=0: CHK_IDLE goes directly to CHK_DONE with no reads and invalid=0.
- num_poly > NUM_POLY_MAX: clamped to NUM_POLY_MAX.
- en while busy: ignored. en in the CHK_DONE cycle: ignored, because it is not yet CHK_IDLE.
- user_bound=0: every coefficient fails.

Decomposition:
- Package norm_check_defines_pkg holds:
  - chk_norm_mode_t with encodings z_bound=0, r0_bound=1, ct0_bound=2, user_bound=3
  - chk_read_state_e
  - Default bound constants
- Sub-module norm_check_lane: one coefficient, combinational centring plus compare producing a fail bit. Instantiated NUM_LANES times.

Test Plan:
- z_bound boundary: mode=z_bound, num_poly=1, all coeffs 0 except word 5 lane 2 = 524092 -> done at k+67, invalid=1, fail_word=5, fail_lane_mask=4'b0100. Repeat with 524091 and with 7856326 -> invalid=0. Repeat with 7856325 -> invalid=1.
- r0/ct0 boundaries: mode=r0_bound, coeff 261692 -> fail. mode=ct0_bound, same coeff 261692 -> pass, coeff 261888 -> fail. A coeff of 8380417 (=Q) in any mode -> fail.
- Early abort: num_poly=7, abort_on_fail=1, failure at word 10 -> rd_en deasserts by word 13, done within 3 cycles after, fail_word=10. With abort_on_fail=0 -> all 448 reads issued, fail_word still 10.
- Address wrap and user bound: base=0x7FFE, num_poly=1, mode=user_bound, user_bound=100 -> addresses 0x7FFE, 0x7FFF, 0x0000, ...; coeff Q-100 fails and coeff Q-99 passes.
- Control boundaries:
  - num_poly=0 -> done at k+1, invalid=0.
  - en pulsed while busy -> ignored.
  - zeroize at word 30 -> idle next cycle, all outputs 0, no done.
  - reset asserted mid-run -> same result asynchronously.
